// File: rtl/dbg_abs_cmd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dbg_abs_cmd : debug-module abstract-command engine (access-register only)  |
// | Optional: DBG_AARPOSTINC_EN enables aarpostinc regno post-increment.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dbg_abs_cmd #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        data0_wr,
  input  logic [31:0] data0_wdata,
  input  logic [2:0]  cmderr_clr,
  input  logic        core_halted,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic [31:0] data0,
  output logic        dbg_reg_access,
  output logic        dbg_wr1_rd0,
  output logic [15:0] dbg_regno,
  output logic [31:0] dbg_write_data,
  input  logic        dbg_read_data_valid,
  input  logic [31:0] dbg_read_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef DBG_AARPOSTINC_EN
  localparam logic POSTINC_OK = 1'b1;
`else
  localparam logic POSTINC_OK = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic [2:0]       cmderr_q, cmderr_d;
  logic [31:0]      data0_q, data0_d;
  logic [15:0]      regno_q, regno_d;
  logic             write_q, write_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       err_set;
  logic [2:0] err_code;
  logic       busy_hit;
  logic       xfer_ok;

  logic [7:0] cmd_type;
  logic [2:0] cmd_aarsize;
  logic       cmd_postinc;
  logic       cmd_postexec;
  logic       cmd_transfer;
  logic       cmd_write;
  logic       cmd_unsupported;

  assign cmd_type        = cmd_wdata[31:24];
  assign cmd_aarsize     = cmd_wdata[22:20];
  assign cmd_postinc     = cmd_wdata[19];
  assign cmd_postexec    = cmd_wdata[18];
  assign cmd_transfer    = cmd_wdata[17];
  assign cmd_write       = cmd_wdata[16];
  assign cmd_unsupported = (cmd_type != 8'd0) || (cmd_aarsize != 3'd2) || cmd_postexec ||
                           (cmd_postinc && !POSTINC_OK);

`ifdef DBG_AARPOSTINC_EN
  logic postinc_q, postinc_d;
  logic unused_bits;
  assign unused_bits = cmd_wdata[23];
`else
  logic unused_bits;
  assign unused_bits = ^{cmd_wdata[23], xfer_ok};
`endif

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cmderr_q <= 3'd0;
      data0_q  <= 32'd0;
      regno_q  <= 16'd0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cmderr_q <= cmderr_d;
      data0_q  <= data0_d;
      regno_q  <= regno_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef DBG_AARPOSTINC_EN
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) postinc_q <= 1'b0;
    else         postinc_q <= postinc_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    data0_d  = data0_q;
    regno_d  = regno_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    err_code = 3'd0;
    xfer_ok  = 1'b0;
`ifdef DBG_AARPOSTINC_EN
    postinc_d = postinc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data0_wr) data0_d = data0_wdata;
        if (cmd_wr && (cmderr_q == 3'd0)) begin
          if (cmd_unsupported) begin
            err_set  = 1'b1;
            err_code = 3'd2;
          end else if (cmd_transfer && !core_halted) begin
            err_set  = 1'b1;
            err_code = 3'd4;
          end else if (!cmd_transfer) begin
            state_d = S_DONE;
          end else begin
            regno_d = cmd_wdata[15:0];
            write_d = cmd_write;
`ifdef DBG_AARPOSTINC_EN
            postinc_d = cmd_postinc;
`endif
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (write_q) begin
          xfer_ok = 1'b1;
          state_d = S_DONE;
        end else if (dbg_read_data_valid) begin
          data0_d = dbg_read_data;
          xfer_ok = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The ISSUE cycle counts toward the timeout, so abort one short of TIMEOUT.
        if (dbg_read_data_valid) begin
          data0_d = dbg_read_data;
          xfer_ok = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_set  = 1'b1;
          err_code = 3'd3;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef DBG_AARPOSTINC_EN
    if (xfer_ok && postinc_q) regno_d = regno_q + 16'd1;
`endif
  end

  assign busy_hit = (cmd_wr || data0_wr) && (state_q != S_IDLE);
  assign busy_d   = (state_d != S_IDLE);

  // A newly detected error overrides a clear arriving in the same cycle.
  always_comb begin
    cmderr_d = cmderr_q & ~cmderr_clr;
    if (cmderr_q == 3'd0) begin
      if (err_set)       cmderr_d = err_code;
      else if (busy_hit) cmderr_d = 3'd1;
    end
  end

  always_comb begin
    dbg_reg_access = (state_q == S_ISSUE) || (state_q == S_WAIT);
    dbg_wr1_rd0    = dbg_reg_access && write_q;
    dbg_regno      = regno_q;
    dbg_write_data = data0_q;
    busy           = busy_q;
    cmderr         = cmderr_q;
    data0          = data0_q;
  end

endmodule
`default_nettype wire

// File: doc/dbg_abs_cmd.md
Name: dbg_abs_cmd

Overview:
Debug-module abstract-command engine; the initiator side of the core debug register-access interface (dbg_reg_access / dbg_wr1_rd0 / dbg_regno / dbg_write_data → dbg_read_data_valid / dbg_read_data).
- Accepts RISC-V debug "access register" commands and data0 writes from the DMI register decoder.
- Sequences one register access per command.
- Returns read data into data0 and reports busy and cmderr.

Parameters:
TIMEOUT, 16, max cycles in WAIT for dbg_read_data_valid before the command aborts with cmderr=3
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
cpu_clk  input  1  cpu clock
cpu_rst  input  1  asynchronous reset, active-high
cmd_wr  input  1  one-cycle pulse: command register written
cmd_wdata  input  32  command word {cmdtype[31:24], rsvd[23], aarsize[22:20], aarpostinc[19], postexec[18], transfer[17], write[16], regno[15:0]}
data0_wr  input  1  one-cycle pulse: data0 written by DMI
data0_wdata  input  32  data0 write value
cmderr_clr  input  3  write-1-to-clear mask for cmderr, sampled every cycle
core_halted  input  1  hart halted status
busy  output  1  command in progress
cmderr  output  3  sticky error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume
data0  output  32  data0 register
dbg_reg_access  output  1  register access request
dbg_wr1_rd0  output  1  1 = write, 0 = read
dbg_regno  output  16  register number
dbg_write_data  output  32  write data (data0)
dbg_read_data_valid  input  1  read data valid
dbg_read_data  input  32  read data

Behaviour:
- Reset (async, cpu_rst=1): state=IDLE, busy=0, cmderr=0, data0=0, dbg_reg_access=0, dbg_wr1_rd0=0, dbg_regno=0, dbg_write_data=0, counter=0. Reset mid-command aborts with no further access.
- FSM states:
  - IDLE.
  - ISSUE: 1 cycle.
  - WAIT: reads only.
  - DONE: 1 cycle, then IDLE.
- Command acceptance, in IDLE with cmd_wr=1 and cmderr==0, checked in this priority:
  - cmdtype!=0, aarsize!=2, or postexec=1 → cmderr=2, stay IDLE.
  - transfer=1 and core_halted=0 → cmderr=4, stay IDLE.
  - transfer=0 → DONE (no access, no error).
  - Otherwise latch regno/write → ISSUE.
- cmd_wr while cmderr!=0 is ignored.
- cmd_wr or data0_wr while busy → cmderr=1 if cmderr==0; the write is discarded; the command in flight continues.
- busy is registered: 1 from the cycle after an accepted cmd_wr through DONE inclusive; 0 in IDLE.
- ISSUE:
  - dbg_reg_access=1; dbg_wr1_rd0=write; dbg_regno=latched regno; dbg_write_data=data0.
  - Write: → DONE; single-cycle access, no acknowledge expected.
  - Read with dbg_read_data_valid=1 the same cycle: data0<=dbg_read_data → DONE.
  - Read otherwise: → WAIT, counter=1.
- WAIT:
  - dbg_reg_access, dbg_wr1_rd0, and dbg_regno are held.
  - valid=1 → capture data0 → DONE.
  - Counter reaching TIMEOUT without valid → cmderr=3 → DONE; data0 unchanged.
  - Counter increments by 1 per cycle.
- dbg_reg_access=0 in IDLE and DONE. dbg_read_data_valid outside ISSUE/WAIT is ignored.
- data0_wr in IDLE: data0<=data0_wdata. A capture from dbg_read_data and a data0_wr never coincide, because the write is blocked while busy.
- cmderr:
  - cmderr<=cmderr & ~cmderr_clr each cycle.
  - If an error is set in the same cycle as a clear, the new error wins.
  - Only the first error is recorded while cmderr!=0.

Optional Feature:
DBG_AARPOSTINC_EN
- Defined: aarpostinc=1 is accepted. After a successful transfer (DONE entered without error), the stored regno increments by 1, wrapping 16'hffff→16'h0000. A subsequent command with cmd_wr carrying aarpostinc=1 and regno equal to the stored value reuses it.
- Not defined: aarpostinc=1 → cmderr=2, no access.

Test Plan:
1. Reset → busy=0, cmderr=0, data0=0; then with core_halted=1: data0_wr 32'h1234_5678, cmd_wr 32'h0023_1005 → one cycle with dbg_reg_access=1, dbg_wr1_rd0=1, dbg_regno=16'h1005, dbg_write_data=32'h1234_5678; busy=1 for 2 cycles; cmderr=0.
2. Read with the responder returning valid in the same cycle, cmd_wr 32'h0022_100a and dbg_read_data=32'hdead_beef → data0=32'hdead_beef; busy high exactly 2 cycles.
3. Read where the responder never asserts valid, cmd_wr 32'h0022_0300 → dbg_reg_access held 16 cycles; cmderr=3; data0 unchanged; then cmderr_clr=3'b111 → cmderr=0.
4. Rejections:
   - cmd_wr 32'h0122_1000 (cmdtype 1) → cmderr=2, no access.
   - After clearing, core_halted=0 with cmd_wr 32'h0022_1000 → cmderr=4, no access.
5. cmd_wr during busy → cmderr=1 and the first command completes normally; a further cmd_wr with cmderr=1 → no access until cleared.
6. Post-increment, with DBG_AARPOSTINC_EN defined: cmd_wr 32'h002a_101f (read, aarpostinc) → stored regno=16'h1020. Without the macro, the same command → cmderr=2, no access.
